// File: rtl/nn_frame_sequencer.sv
// Frames a sample stream around an HLS core's ap_fifo ports: one inference at a time,
// exactly size_input samples in (pad/discard), exactly size_output results out with tlast.
module nn_frame_sequencer #(
    parameter int DWIDTH = 16,
    parameter int UWIDTH = 128,
    parameter int CWIDTH = 16
) (
    input  logic              ce_clk,
    input  logic              ce_rst,
    input  logic              clear,
    input  logic [CWIDTH-1:0] size_input,
    input  logic [CWIDTH-1:0] size_output,
    input  logic [DWIDTH-1:0] i_tdata,
    input  logic [UWIDTH-1:0] i_tuser,
    input  logic              i_tlast,
    input  logic              i_tvalid,
    output logic              i_tready,
    output logic [DWIDTH-1:0] core_dout,
    output logic              core_empty_n,
    input  logic              core_read,
    input  logic [DWIDTH-1:0] core_din,
    output logic              core_full_n,
    input  logic              core_write,
    output logic [DWIDTH-1:0] o_tdata,
    output logic [UWIDTH-1:0] o_tuser,
    output logic              o_tlast,
    output logic              o_tvalid,
    input  logic              o_tready,
    output logic              busy,
    output logic [CWIDTH-1:0] frame_count,
    output logic [CWIDTH-1:0] pad_count,
    output logic [CWIDTH-1:0] drop_count
);

    localparam logic [CWIDTH-1:0] CNT_ONE  = {{(CWIDTH-1){1'b0}}, 1'b1};
    localparam logic [CWIDTH-1:0] CNT_ZERO = {CWIDTH{1'b0}};

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FEED     = 3'd1,
        ST_PAD      = 3'd2,
        ST_DISCARD  = 3'd3,
        ST_WAIT_OUT = 3'd4
    } state_t;

    state_t            state_r, state_s;
    logic [UWIDTH-1:0] hdr_r;
    logic [CWIDTH-1:0] s_in_r, s_out_r, in_cnt_r, out_cnt_r;
    logic [CWIDTH-1:0] frame_cnt_r, pad_cnt_r, drop_cnt_r;
    logic              out_done_r;

    logic start_s, in_inc_s, pad_inc_s, drop_inc_s, frame_inc_s;
    logic in_last_s, out_active_s, out_last_s, out_hs_s, out_done_s;

    assign in_last_s   = (in_cnt_r == (s_in_r - CNT_ONE));
    assign busy        = (state_r != ST_IDLE);
    assign o_tuser     = hdr_r;
    assign frame_count = frame_cnt_r;
    assign pad_count   = pad_cnt_r;
    assign drop_count  = drop_cnt_r;

    // Output side: results pass straight through until size_output handshakes, then stall the core
    always_comb begin
        out_active_s = (state_r != ST_IDLE) && !out_done_r;
        out_last_s   = (out_cnt_r == (s_out_r - CNT_ONE));
        out_hs_s     = out_active_s && core_write && o_tready;
        out_done_s   = out_done_r || (out_hs_s && out_last_s);
        o_tvalid     = out_active_s && core_write;
        o_tdata      = out_active_s ? core_din : {DWIDTH{1'b0}};
        o_tlast      = out_active_s && out_last_s;
        core_full_n  = out_active_s && o_tready;
    end

    // Input-side next state and core feed/handshake outputs
    always_comb begin
        state_s      = state_r;
        i_tready     = 1'b0;
        core_empty_n = 1'b0;
        core_dout    = {DWIDTH{1'b0}};
        start_s      = 1'b0;
        in_inc_s     = 1'b0;
        pad_inc_s    = 1'b0;
        drop_inc_s   = 1'b0;
        frame_inc_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (i_tvalid) begin
                    start_s = 1'b1;
                    state_s = ST_FEED;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_FEED: begin
                core_dout    = i_tdata;
                core_empty_n = i_tvalid;
                i_tready     = core_read;
                if (i_tvalid && core_read) begin
                    in_inc_s = 1'b1;
                    if (in_last_s) begin
                        state_s = i_tlast ? ST_WAIT_OUT : ST_DISCARD;
                    end else if (i_tlast) begin
                        pad_inc_s = 1'b1;
                        state_s   = ST_PAD;
                    end else begin
                        state_s = ST_FEED;
                    end
                end else begin
                    state_s = ST_FEED;
                end
            end
            ST_PAD: begin
                core_empty_n = 1'b1;
                if (core_read) begin
                    in_inc_s = 1'b1;
                    state_s  = in_last_s ? ST_WAIT_OUT : ST_PAD;
                end else begin
                    state_s = ST_PAD;
                end
            end
            ST_DISCARD: begin
                i_tready = 1'b1;
                if (i_tvalid) begin
                    drop_inc_s = 1'b1;
                    state_s    = i_tlast ? ST_WAIT_OUT : ST_DISCARD;
                end else begin
                    state_s = ST_DISCARD;
                end
            end
            ST_WAIT_OUT: begin
                if (out_done_s) begin
                    frame_inc_s = 1'b1;
                    state_s     = ST_IDLE;
                end else begin
                    state_s = ST_WAIT_OUT;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, per-frame latches and status counters
    always_ff @(posedge ce_clk) begin
        if (ce_rst || clear) begin
            state_r     <= ST_IDLE;
            hdr_r       <= {UWIDTH{1'b0}};
            s_in_r      <= CNT_ONE;
            s_out_r     <= CNT_ONE;
            in_cnt_r    <= CNT_ZERO;
            out_cnt_r   <= CNT_ZERO;
            out_done_r  <= 1'b0;
            frame_cnt_r <= CNT_ZERO;
            pad_cnt_r   <= CNT_ZERO;
            drop_cnt_r  <= CNT_ZERO;
        end else begin
            state_r <= state_s;
            if (start_s) begin
                // Header is captured only here, so it always belongs to the frame being processed
                hdr_r      <= i_tuser;
                s_in_r     <= (size_input == CNT_ZERO) ? CNT_ONE : size_input;
                s_out_r    <= (size_output == CNT_ZERO) ? CNT_ONE : size_output;
                in_cnt_r   <= CNT_ZERO;
                out_cnt_r  <= CNT_ZERO;
                out_done_r <= 1'b0;
            end else begin
                if (in_inc_s) in_cnt_r <= in_cnt_r + CNT_ONE;
                if (out_hs_s) out_cnt_r <= out_cnt_r + CNT_ONE;
                if (out_hs_s && out_last_s) out_done_r <= 1'b1;
            end
            if (frame_inc_s) frame_cnt_r <= frame_cnt_r + CNT_ONE;
            if (pad_inc_s)   pad_cnt_r   <= pad_cnt_r + CNT_ONE;
            if (drop_inc_s)  drop_cnt_r  <= drop_cnt_r + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_nn_frame_sequencer.sv
// Directed bench for nn_frame_sequencer: exact, short, long, stalled-output,
// back-to-back and mid-frame-reset packets, with hand-derived expectations.
module tb_nn_frame_sequencer;

    logic         ce_clk = 1'b0;
    logic         ce_rst = 1'b1;
    logic         clear = 1'b0;
    logic [15:0]  size_input = 16'd8;
    logic [15:0]  size_output = 16'd4;
    logic [15:0]  i_tdata = 16'd0;
    logic [127:0] i_tuser = 128'd0;
    logic         i_tlast = 1'b0;
    logic         i_tvalid = 1'b0;
    logic         i_tready;
    logic [15:0]  core_dout;
    logic         core_empty_n;
    logic         core_read = 1'b0;
    logic [15:0]  core_din = 16'd0;
    logic         core_full_n;
    logic         core_write = 1'b0;
    logic [15:0]  o_tdata;
    logic [127:0] o_tuser;
    logic         o_tlast;
    logic         o_tvalid;
    logic         o_tready = 1'b0;
    logic         busy;
    logic [15:0]  frame_count, pad_count, drop_count;

    int total = 0;
    int passed = 0;

    nn_frame_sequencer dut (
        .ce_clk(ce_clk), .ce_rst(ce_rst), .clear(clear),
        .size_input(size_input), .size_output(size_output),
        .i_tdata(i_tdata), .i_tuser(i_tuser), .i_tlast(i_tlast),
        .i_tvalid(i_tvalid), .i_tready(i_tready),
        .core_dout(core_dout), .core_empty_n(core_empty_n), .core_read(core_read),
        .core_din(core_din), .core_full_n(core_full_n), .core_write(core_write),
        .o_tdata(o_tdata), .o_tuser(o_tuser), .o_tlast(o_tlast),
        .o_tvalid(o_tvalid), .o_tready(o_tready),
        .busy(busy), .frame_count(frame_count), .pad_count(pad_count),
        .drop_count(drop_count)
    );

    always #5 ce_clk = ~ce_clk;

    task automatic check_counters(input string name, input int f, input int p, input int d);
        total++;
        if (frame_count !== 16'(f) || pad_count !== 16'(p) || drop_count !== 16'(d)) begin
            $display("FAIL %s: frame/pad/drop got %0d/%0d/%0d expected %0d/%0d/%0d",
                     name, frame_count, pad_count, drop_count, f, p, d);
        end else passed++;
    endtask

    // Sends an n-sample packet with the core reading continuously; covers feed, pad and discard.
    task automatic send_packet(input logic [127:0] hdr, input int n, input int s_in, input bit bubble);
        bit ok;
        i_tuser = hdr; i_tvalid = 1'b1; i_tdata = 16'h1000; i_tlast = (n == 1); core_read = 1'b1;
        if (bubble) begin
            #1;
            total++;
            if (i_tready !== 1'b0 || core_empty_n !== 1'b0) begin
                $display("FAIL idle_bubble: i_tready=%b core_empty_n=%b expected 0/0", i_tready, core_empty_n);
            end else passed++;
            @(posedge ce_clk); #1;
        end
        for (int j = 0; j < n; j++) begin
            i_tdata = 16'(16'h1000 + j); i_tlast = (j == n - 1); i_tvalid = 1'b1;
            #1;
            if (j < s_in) ok = (core_dout === i_tdata && core_empty_n === 1'b1 && i_tready === 1'b1);
            else          ok = (core_dout === 16'd0 && core_empty_n === 1'b0 && i_tready === 1'b1);
            total++;
            if (!ok) begin
                $display("FAIL feed_sample%0d: dout=%h empty_n=%b ready=%b expected dout=%h empty_n=%b ready=1",
                         j, core_dout, core_empty_n, i_tready, (j < s_in) ? i_tdata : 16'd0, (j < s_in));
            end else passed++;
            @(posedge ce_clk); #1;
        end
        i_tvalid = 1'b0; i_tlast = 1'b0;
        for (int p = n; p < s_in; p++) begin
            #1;
            total++;
            if (core_dout !== 16'd0 || core_empty_n !== 1'b1 || i_tready !== 1'b0) begin
                $display("FAIL pad_slot%0d: dout=%h empty_n=%b ready=%b expected 0000/1/0",
                         p, core_dout, core_empty_n, i_tready);
            end else passed++;
            @(posedge ce_clk); #1;
        end
        core_read = 1'b0;
    endtask

    // Drains nout results; toggle makes o_tready alternate 1/0 every cycle.
    task automatic recv_results(input logic [127:0] hdr, input int nout, input bit toggle);
        int k = 0;
        int cyc = 0;
        core_write = 1'b1; core_din = 16'hA000;
        while (k < nout && cyc < 64) begin
            o_tready = toggle ? ~cyc[0] : 1'b1;
            #1;
            total++;
            if (o_tvalid !== 1'b1 || o_tuser !== hdr || o_tdata !== core_din ||
                o_tlast !== (k == nout - 1) || core_full_n !== o_tready) begin
                $display("FAIL result%0d: valid=%b tdata=%h tlast=%b full_n=%b tuser=%h expected 1/%h/%b/%b/%h",
                         k, o_tvalid, o_tdata, o_tlast, core_full_n, o_tuser,
                         core_din, (k == nout - 1), o_tready, hdr);
            end else passed++;
            if (o_tready) k++;
            @(posedge ce_clk); #1;
            cyc++;
            core_din = 16'(16'hA000 + k);
        end
        if (k < nout) begin
            total++;
            $display("FAIL recv_timeout: got %0d results expected %0d", k, nout);
        end
        o_tready = 1'b1;
    endtask

    task automatic test_reset();
        ce_rst = 1'b1;
        repeat (2) @(posedge ce_clk);
        #1; ce_rst = 1'b0;
        total++;
        if (busy !== 1'b0 || i_tready !== 1'b0 || core_empty_n !== 1'b0 || core_full_n !== 1'b0 ||
            o_tvalid !== 1'b0 || o_tlast !== 1'b0 || o_tdata !== 16'd0 || o_tuser !== 128'd0) begin
            $display("FAIL reset_outputs: busy=%b ready=%b empty_n=%b full_n=%b valid=%b last=%b expected all 0",
                     busy, i_tready, core_empty_n, core_full_n, o_tvalid, o_tlast);
        end else passed++;
        check_counters("reset_counters", 0, 0, 0);
    endtask

    task automatic test_exact();
        send_packet(128'h0123_4567_89AB_CDEF_0000_0000_0000_0001, 8, 8, 1'b1);
        recv_results(128'h0123_4567_89AB_CDEF_0000_0000_0000_0001, 4, 1'b0);
        core_write = 1'b0;
        total++;
        if (busy !== 1'b0) $display("FAIL exact_idle: busy=%b expected 0", busy);
        else passed++;
        check_counters("exact_counters", 1, 0, 0);
    endtask

    task automatic test_pad();
        send_packet(128'h2, 5, 8, 1'b1);
        recv_results(128'h2, 4, 1'b0);
        core_write = 1'b0;
        check_counters("pad_counters", 2, 1, 0);
    endtask

    task automatic test_discard();
        send_packet(128'h3, 11, 8, 1'b1);
        recv_results(128'h3, 4, 1'b0);
        core_write = 1'b0;
        check_counters("discard_counters", 3, 1, 3);
        send_packet(128'h4444, 8, 8, 1'b1);
        recv_results(128'h4444, 4, 1'b0);
        core_write = 1'b0;
        check_counters("after_discard_counters", 4, 1, 3);
    endtask

    task automatic test_output_stall();
        i_tuser = 128'h55; i_tvalid = 1'b1;
        @(posedge ce_clk); #1;
        i_tvalid = 1'b0;
        recv_results(128'h55, 4, 1'b0);
        #1;
        total++;
        if (core_full_n !== 1'b0 || o_tvalid !== 1'b0 || busy !== 1'b1) begin
            $display("FAIL stall_fifth_write: full_n=%b valid=%b busy=%b expected 0/0/1",
                     core_full_n, o_tvalid, busy);
        end else passed++;
        core_write = 1'b0;
        send_packet(128'h55, 8, 8, 1'b0);
        total++;
        if (busy !== 1'b1 || frame_count !== 16'd4) begin
            $display("FAIL stall_wait_out: busy=%b frame=%0d expected 1/4", busy, frame_count);
        end else passed++;
        @(posedge ce_clk); #1;
        total++;
        if (busy !== 1'b0) $display("FAIL stall_exit: busy=%b expected 0", busy);
        else passed++;
        check_counters("stall_counters", 5, 1, 3);
    endtask

    task automatic test_back_to_back();
        clear = 1'b1;
        @(posedge ce_clk); #1;
        clear = 1'b0;
        check_counters("clear_counters", 0, 0, 0);
        for (int f = 0; f < 3; f++) begin
            send_packet(128'(128'hA0 + f), 8, 8, 1'b1);
            recv_results(128'(128'hA0 + f), 4, 1'b1);
            core_write = 1'b0;
        end
        check_counters("b2b_counters", 3, 0, 0);
    endtask

    task automatic test_reset_midframe();
        i_tuser = 128'h77; i_tvalid = 1'b1; core_read = 1'b1;
        @(posedge ce_clk); #1;
        for (int j = 0; j < 3; j++) begin
            i_tdata = 16'(j);
            @(posedge ce_clk); #1;
        end
        ce_rst = 1'b1;
        @(posedge ce_clk); #1;
        ce_rst = 1'b0; i_tvalid = 1'b0; core_read = 1'b0; core_write = 1'b1;
        #1;
        total++;
        if (busy !== 1'b0 || i_tready !== 1'b0 || o_tvalid !== 1'b0 || o_tuser !== 128'd0) begin
            $display("FAIL midreset_outputs: busy=%b ready=%b valid=%b tuser=%h expected 0/0/0/0",
                     busy, i_tready, o_tvalid, o_tuser);
        end else passed++;
        check_counters("midreset_counters", 0, 0, 0);
        core_write = 1'b0;
        @(posedge ce_clk); #1;
        send_packet(128'h88, 8, 8, 1'b1);
        recv_results(128'h88, 4, 1'b0);
        core_write = 1'b0;
        check_counters("post_reset_counters", 1, 0, 0);
    endtask

    initial begin
        test_reset();
        test_exact();
        test_pad();
        test_discard();
        test_output_stall();
        test_back_to_back();
        test_reset_midframe();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
